// File: rtl/cdb_broadcaster_pkg.sv
// Shared widths for the common data bus and the reorder buffer.
// DATA_W    : result data width carried on the CDB.
// CNT_W     : width of the broadcast counter.
// ROB_TAG_W : reference id (ROB tag) width.
package cdb_broadcaster_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ROB_TAG_W = 32;

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Round-robin priority selector.
// Ports:
//   req_i   : per-requester request vector
//   ptr_i   : index with highest priority this cycle
//   grant_o : one-hot grant, first set req_i bit scanning upward from ptr_i
//             modulo NUM_REQ; all zero when no request is set
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic found;

  // Offset k selects the candidate (ptr+k) mod NUM_REQ; the inner loop keeps
  // every index constant so NUM_REQ need not be a power of two.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] &&
            (i == ((int'(ptr_i) + k) % NUM_REQ))) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: round-robin arbitration among functional-unit
// results, then a one-cycle registered broadcast of the winner's primary and
// optional lo result.
// Ports:
//   clk, rst (async active-low), flush (sync, cancels arbitration/broadcast)
//   req_valid / req_ref_id / req_data        : per-requester primary result
//   req_lo_en / req_lo_ref_id / req_lo_data  : per-requester lo result
//   req_ready                                : combinational one-hot grant
//   bus_en / bus_ref_id / bus_data           : primary broadcast
//   bus_lo_en / bus_lo_ref_id / bus_lo_data  : lo broadcast
//   bcast_count                              : completed broadcasts, wrapping
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ROB_TAG_W-1:0]   req_ref_id,
  input  logic [NUM_REQ*DATA_W-1:0]      req_data,
  input  logic [NUM_REQ-1:0]             req_lo_en,
  input  logic [NUM_REQ*ROB_TAG_W-1:0]   req_lo_ref_id,
  input  logic [NUM_REQ*DATA_W-1:0]      req_lo_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           bus_en,
  output logic [ROB_TAG_W-1:0]           bus_ref_id,
  output logic [DATA_W-1:0]              bus_data,
  output logic                           bus_lo_en,
  output logic [ROB_TAG_W-1:0]           bus_lo_ref_id,
  output logic [DATA_W-1:0]              bus_lo_data,
  output logic [CNT_W-1:0]               bcast_count
);

  logic [NUM_REQ-1:0]   req_eff;
  logic [NUM_REQ-1:0]   grant;
  logic                 hs;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ROB_TAG_W-1:0] sel_ref, sel_lo_ref;
  logic [DATA_W-1:0]    sel_data, sel_lo_data;
  logic                 sel_lo_en;

  logic                 bus_en_q, bus_lo_en_q;
  logic [ROB_TAG_W-1:0] bus_ref_q, bus_lo_ref_q;
  logic [DATA_W-1:0]    bus_data_q, bus_lo_data_q;
  logic [CNT_W-1:0]     count_q;

  // Gating the request vector keeps req_ready low during reset and flush
  // without a separate mask on the arbiter output.
  assign req_eff = (rst && !flush) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (req_eff),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  always_comb begin
    sel_ref     = '0;
    sel_data    = '0;
    sel_lo_ref  = '0;
    sel_lo_data = '0;
    sel_lo_en   = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_ref     = req_ref_id[i*ROB_TAG_W +: ROB_TAG_W];
        sel_data    = req_data[i*DATA_W +: DATA_W];
        sel_lo_ref  = req_lo_ref_id[i*ROB_TAG_W +: ROB_TAG_W];
        sel_lo_data = req_lo_data[i*DATA_W +: DATA_W];
        sel_lo_en   = req_lo_en[i];
        rr_ptr_d    = PTR_W'((i + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      bus_en_q      <= 1'b0;
      bus_lo_en_q   <= 1'b0;
      bus_ref_q     <= '0;
      bus_data_q    <= '0;
      bus_lo_ref_q  <= '0;
      bus_lo_data_q <= '0;
      count_q       <= '0;
    end else begin
      bus_en_q    <= hs;
      bus_lo_en_q <= hs && sel_lo_en;
      rr_ptr_q    <= rr_ptr_d;
      if (hs) begin
        bus_ref_q  <= sel_ref;
        bus_data_q <= sel_data;
        count_q    <= count_q + CNT_W'(1);
      end
      if (hs && sel_lo_en) begin
        bus_lo_ref_q  <= sel_lo_ref;
        bus_lo_data_q <= sel_lo_data;
      end
    end
  end

  assign bus_en        = bus_en_q;
  assign bus_lo_en     = bus_lo_en_q;
  assign bus_ref_id    = bus_ref_q;
  assign bus_data      = bus_data_q;
  assign bus_lo_ref_id = bus_lo_ref_q;
  assign bus_lo_data   = bus_lo_data_q;
  assign bcast_count   = count_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   req_valid;
  logic [127:0] req_ref_id, req_data, req_lo_ref_id, req_lo_data;
  logic [3:0]   req_lo_en;
  logic [3:0]   req_ready;
  logic         bus_en, bus_lo_en;
  logic [31:0]  bus_ref_id, bus_data, bus_lo_ref_id, bus_lo_data;
  logic [15:0]  bcast_count;

  logic [31:0]  ref_a[4], data_a[4], lo_ref_a[4], lo_data_a[4];

  int errors = 0;
  int checks = 0;
  int cnt_exp = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign req_ref_id[32*i +: 32]    = ref_a[i];
    assign req_data[32*i +: 32]      = data_a[i];
    assign req_lo_ref_id[32*i +: 32] = lo_ref_a[i];
    assign req_lo_data[32*i +: 32]   = lo_data_a[i];
  end

  cdb_broadcaster #(.NUM_REQ(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ref_id(req_ref_id), .req_data(req_data),
    .req_lo_en(req_lo_en), .req_lo_ref_id(req_lo_ref_id), .req_lo_data(req_lo_data),
    .req_ready(req_ready),
    .bus_en(bus_en), .bus_ref_id(bus_ref_id), .bus_data(bus_data),
    .bus_lo_en(bus_lo_en), .bus_lo_ref_id(bus_lo_ref_id), .bus_lo_data(bus_lo_data),
    .bcast_count(bcast_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_of(int g);     return 32'h100 + g;       endfunction
  function automatic logic [31:0] data_of(int g);    return 32'hA000_0000 + g; endfunction
  function automatic logic [31:0] lo_ref_of(int g);  return 32'h200 + g;       endfunction
  function automatic logic [31:0] lo_data_of(int g); return 32'hB000_0000 + g; endfunction

  task automatic default_payload();
    for (int i = 0; i < 4; i++) begin
      ref_a[i]     = ref_of(i);
      data_a[i]    = data_of(i);
      lo_ref_a[i]  = lo_ref_of(i);
      lo_data_a[i] = lo_data_of(i);
    end
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] lo;
    logic       f;
    logic [3:0] rdy;
    logic       en;
    int         g;    // requester whose payload is expected on the bus (held if en=0)
    logic       lo_x;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int n;
    // Pointer evolution annotated per row (value before the row's edge).
    vecs[0]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 1, 1'b0}; // ptr0
    vecs[1]  = '{4'b0110, 4'b0000, 1'b0, 4'b0100, 1'b1, 2, 1'b0}; // ptr2
    vecs[2]  = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 1, 1'b0}; // ptr3 wraps
    vecs[3]  = '{4'b0110, 4'b0000, 1'b0, 4'b0100, 1'b1, 2, 1'b0}; // ptr2
    vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2, 1'b0}; // ptr3 idle
    vecs[5]  = '{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 3, 1'b1}; // ptr3
    vecs[6]  = '{4'b1111, 4'b0101, 1'b0, 4'b0001, 1'b1, 0, 1'b1}; // ptr0
    vecs[7]  = '{4'b1111, 4'b0101, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
    vecs[8]  = '{4'b1111, 4'b0101, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0101, 1'b0, 4'b1000, 1'b1, 3, 1'b0};
    vecs[10] = '{4'b1111, 4'b0101, 1'b0, 4'b0001, 1'b1, 0, 1'b1};
    vecs[11] = '{4'b1111, 4'b0101, 1'b0, 4'b0010, 1'b1, 1, 1'b0};
    vecs[12] = '{4'b1111, 4'b0101, 1'b0, 4'b0100, 1'b1, 2, 1'b1};
    vecs[13] = '{4'b1111, 4'b0101, 1'b0, 4'b1000, 1'b1, 3, 1'b0};
    vecs[14] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 0, 1'b0}; // ptr0 -> 1
    vecs[15] = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0}; // flush, ptr holds 1
    vecs[16] = '{4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 1, 1'b0}; // ptr1

    default_payload();
    rst = 1'b0; flush = 1'b0; req_valid = 4'b1111; req_lo_en = 4'b1111;

    // Reset state
    #3;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_bus_en", 32'(bus_en), 32'h0);
    chk("rst_lo_en", 32'(bus_lo_en), 32'h0);
    chk("rst_ref", bus_ref_id, 32'h0);
    chk("rst_data", bus_data, 32'h0);
    chk("rst_lo_ref", bus_lo_ref_id, 32'h0);
    chk("rst_lo_data", bus_lo_data, 32'h0);
    chk("rst_count", 32'(bcast_count), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000; req_lo_en = 4'b0000;
    rst = 1'b1;

    // Table-driven arbitration / broadcast vectors
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      req_valid = vecs[k].v; req_lo_en = vecs[k].lo; flush = vecs[k].f;
      #1;
      chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].rdy));
      @(posedge clk); #1;
      if (vecs[k].en) cnt_exp++;
      chk($sformatf("v%0d_bus_en", k), 32'(bus_en), 32'(vecs[k].en));
      chk($sformatf("v%0d_ref", k), bus_ref_id, ref_of(vecs[k].g));
      chk($sformatf("v%0d_data", k), bus_data, data_of(vecs[k].g));
      chk($sformatf("v%0d_lo_en", k), 32'(bus_lo_en), 32'(vecs[k].lo_x));
      if (vecs[k].lo_x) begin
        chk($sformatf("v%0d_lo_ref", k), bus_lo_ref_id, lo_ref_of(vecs[k].g));
        chk($sformatf("v%0d_lo_data", k), bus_lo_data, lo_data_of(vecs[k].g));
      end
      chk($sformatf("v%0d_count", k), 32'(bcast_count), 32'(cnt_exp));
    end

    // Requester 3 with explicit primary and lo payload, then idle
    @(negedge clk);
    flush = 1'b0;
    ref_a[3] = 32'h5; data_a[3] = 32'hDEADBEEF; lo_ref_a[3] = 32'h6; lo_data_a[3] = 32'h1234;
    req_valid = 4'b1000; req_lo_en = 4'b1000;
    #1;
    chk("r3_ready", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    cnt_exp++;
    chk("r3_bus_en", 32'(bus_en), 32'h1);
    chk("r3_ref", bus_ref_id, 32'h5);
    chk("r3_data", bus_data, 32'hDEADBEEF);
    chk("r3_lo_en", 32'(bus_lo_en), 32'h1);
    chk("r3_lo_ref", bus_lo_ref_id, 32'h6);
    chk("r3_lo_data", bus_lo_data, 32'h1234);
    @(negedge clk);
    req_valid = 4'b0000; req_lo_en = 4'b0000;
    default_payload();
    @(posedge clk); #1;
    chk("r3_after_en", 32'(bus_en), 32'h0);
    chk("r3_after_lo_en", 32'(bus_lo_en), 32'h0);
    chk("r3_hold_ref", bus_ref_id, 32'h5);

    // Counter wrap: back-to-back grants up to 0xFFFF, then one more
    n = 65535 - cnt_exp;
    @(negedge clk);
    req_valid = 4'b1111;
    repeat (n) @(posedge clk);
    #1;
    chk("cnt_ffff", 32'(bcast_count), 32'hFFFF);
    chk("cnt_b2b_en", 32'(bus_en), 32'h1);
    @(posedge clk); #1;
    chk("cnt_wrap", 32'(bcast_count), 32'h0);
    @(negedge clk);
    req_valid = 4'b0000;

    // Asynchronous reset while a broadcast is on the bus
    @(negedge clk);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    chk("ar_bus_en_pre", 32'(bus_en), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_bus_en", 32'(bus_en), 32'h0);
    chk("ar_ref", bus_ref_id, 32'h0);
    chk("ar_count", 32'(bcast_count), 32'h0);
    req_valid = 4'b0110;
    #0.5;
    chk("ar_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_first_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    chk("ar_first_ref", bus_ref_id, ref_of(1));
    chk("ar_first_count", 32'(bcast_count), 32'h1);
    @(negedge clk);
    req_valid = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit result requesters; legal values 2..8.
REQ-002 Parameter PTR_W, default 2, round-robin pointer width, equal to ceil(log2(NUM_REQ)).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous pipeline flush; cancels arbitration and broadcast.
REQ-006 req_valid  input  NUM_REQ  per-requester result valid.
REQ-007 req_ref_id  input  NUM_REQ*32  per-requester reference id (ROB tag), requester i in bits [32i+31:32i].
REQ-008 req_data  input  NUM_REQ*32  per-requester result data, same packing.
REQ-009 req_lo_en  input  NUM_REQ  per-requester second (lo) result present.
REQ-010 req_lo_ref_id  input  NUM_REQ*32  per-requester lo reference id.
REQ-011 req_lo_data  input  NUM_REQ*32  per-requester lo result data.
REQ-012 req_ready  output  NUM_REQ  one-hot grant; handshake completes when req_valid[i] and req_ready[i] are both high.
REQ-013 bus_en  output  1  primary CDB broadcast valid.
REQ-014 bus_ref_id  output  32  primary broadcast reference id.
REQ-015 bus_data  output  32  primary broadcast data.
REQ-016 bus_lo_en  output  1  lo CDB broadcast valid.
REQ-017 bus_lo_ref_id  output  32  lo broadcast reference id.
REQ-018 bus_lo_data  output  32  lo broadcast data.
REQ-019 bcast_count  output  16  count of completed broadcasts; wraps 0xFFFF->0x0000.

Function
REQ-020 req_ready SHALL be combinational: at most one bit high, the first i with req_valid[i]=1 scanning upward from rr_ptr modulo NUM_REQ; all zero if no requester is valid or flush=1.
REQ-021 On a handshake with requester g at edge N, rr_ptr SHALL become (g+1) mod NUM_REQ; otherwise rr_ptr holds.
REQ-022 Latency SHALL be one cycle: after edge N, bus_en=1 and bus_ref_id/bus_data equal requester g's inputs sampled at N.
REQ-023 bus_lo_en SHALL be 1 after edge N only if bus_en=1 and req_lo_en[g]=1 at N; bus_lo_ref_id/bus_lo_data then equal requester g's lo inputs.
REQ-024 With no handshake at edge N, bus_en and bus_lo_en SHALL be 0 after N; data outputs hold their last values.
REQ-025 Each broadcast SHALL last exactly one cycle; there is no bus backpressure, and back-to-back handshakes SHALL produce broadcasts on consecutive cycles.
REQ-026 Ungranted requesters SHALL keep req_valid and payload stable until granted; starvation is bounded to NUM_REQ-1 cycles.
REQ-027 flush=1 at edge N SHALL force bus_en=0 and bus_lo_en=0 after N, and rr_ptr and bcast_count hold.
REQ-028 bcast_count SHALL increment by 1 at every edge where bus_en becomes 1.

Reset
REQ-029 While rst=0: req_ready=0, rr_ptr=0, bus_en=0, bus_lo_en=0, bus_ref_id, bus_data, bus_lo_ref_id, bus_lo_data and bcast_count all 0.
REQ-030 Reset mid-broadcast SHALL drop bus_en immediately (asynchronously); the in-flight result is lost.
REQ-031 The first grant after reset SHALL go to the lowest-index valid requester.

Structure
REQ-032 Data width (32) and bcast_count width (16) SHALL come from the shared bus.v constants, and ROB tag width from rob.v; no new package is needed.
REQ-033 The round-robin priority selector SHALL be one sub-module, rr_arbiter (inputs req and ptr; output one-hot grant); the remaining logic is the output register stage.

Verification
REQ-034 Reset, then req_valid=4'b0110 held -> req_ready=4'b0010 then 4'b0100 alternating; bus_ref_id follows requester 1, then 2, each bus_en pulse one cycle.
REQ-035 Requester 3 sends ref_id=0x5, data=0xDEADBEEF, lo_en=1, lo_ref_id=0x6, lo_data=0x1234 -> next cycle: bus_en=1, bus_lo_en=1 with those values; following cycle: both 0.
REQ-036 All four valid for 8 cycles from rr_ptr=0 -> grants 0,1,2,3,0,1,2,3; bcast_count +8.
REQ-037 flush=1 while req_valid=4'b0001 -> req_ready=0, bus_en=0 on the next cycle, rr_ptr unchanged.
REQ-038 Preload bcast_count to 0xFFFF via 65535 broadcasts, then one more -> 0x0000.
REQ-039 rst dropped while bus_en=1 -> bus_en=0 without waiting for a clock edge; after release, the first grant goes to the lowest valid index.
